// File: rtl/clock_core_if.sv
// clock_core_if -- field-write channel from the serial command decoder.
//   set_valid : write request (decoder -> core)
//   set_ready : core can accept a write (core -> decoder)
//   set_sel   : field select, 0 sec / 1 min / 2 hour / 3 alarm min /
//               4 alarm hour / 5 alarm control (decoder -> core)
//   set_value : binary field value (decoder -> core)
//   set_err   : one-cycle pulse after an out-of-range write (core -> decoder)
// Modports: master = command decoder, slave = clock_core.
interface clock_core_if;
    logic       set_valid;
    logic       set_ready;
    logic [2:0] set_sel;
    logic [6:0] set_value;
    logic       set_err;

    modport master (
        output set_valid, set_sel, set_value,
        input  set_ready, set_err
    );

    modport slave (
        input  set_valid, set_sel, set_value,
        output set_ready, set_err
    );
endinterface

// File: rtl/clock_core.sv
// clock_core -- timekeeping stage ahead of the six-digit display driver.
// Divides clk into a one-second tick, keeps hh:mm:ss in binary, accepts
// field writes over a valid/ready handshake and runs a programmable alarm.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   set             : clock_core_if.slave write channel
//   sec_o           : seconds 0..59, or 60 (display blank) while ringing
//   min_o, hour_o   : minutes 0..59, hours 0..23
//   tick_o          : one-cycle pulse with each one-second update
//   alarm_o         : high while ringing
// Parameters: TICK_DIV (clk cycles per second, >= 2),
//             ALARM_SECS (ring duration in seconds, 1..63).
// Build option: define CLOCK_CORE_ALARM_EN to compile in the alarm registers,
// FSM and sec-60 blanking; otherwise sel 3..5 writes are rejected as illegal.
module clock_core #(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned ALARM_SECS = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    clock_core_if.slave        set,
    output logic [6:0]         sec_o,
    output logic [6:0]         min_o,
    output logic [6:0]         hour_o,
    output logic               tick_o,
    output logic               alarm_o
);

    localparam int unsigned    PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);

    if (TICK_DIV < 2 || ALARM_SECS < 1 || ALARM_SECS > 63) begin : g_bad_param
        $error("clock_core: TICK_DIV must be >= 2 and ALARM_SECS in 1..63");
    end

    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [4:0]    hour_q, hour_d;
    logic [6:0]    sec_o_q, sec_o_d;
    logic          tick_q, tick_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;

    logic          accept;
    logic          legal;
    logic          wr;
    logic          time_wr;
    logic          tick_raw;
    logic          tick;

`ifdef CLOCK_CORE_ALARM_EN
    typedef enum logic {
        IDLE,
        RING
    } alarm_state_e;

    localparam logic [5:0] RING_LOAD = 6'(ALARM_SECS);

    alarm_state_e state_q, state_d;
    logic [5:0]   ring_q, ring_d;
    logic [5:0]   amin_q, amin_d;
    logic [4:0]   ahour_q, ahour_d;
    logic         armed_q, armed_d;
    logic         alarm_q, alarm_d;
`endif

    always_comb begin
        accept   = set.set_valid & ready_q;

        case (set.set_sel)
            3'd0, 3'd1: legal = (set.set_value < 7'd60);
            3'd2:       legal = (set.set_value < 7'd24);
`ifdef CLOCK_CORE_ALARM_EN
            3'd3:       legal = (set.set_value < 7'd60);
            3'd4:       legal = (set.set_value < 7'd24);
            3'd5:       legal = 1'b1;
`endif
            default:    legal = 1'b0;
        endcase

        wr       = accept & legal;
        time_wr  = wr & (set.set_sel <= 3'd2);
        tick_raw = (presc_q == PRESC_MAX);
        // A legal time-field write on the tick edge swallows that tick entirely.
        tick     = tick_raw & ~time_wr;

        presc_d  = tick_raw ? '0 : presc_q + 1'b1;
        if (wr && set.set_sel == 3'd0) begin
            presc_d = '0;
        end

        sec_d    = sec_q;
        min_d    = min_q;
        hour_d   = hour_q;
        if (tick) begin
            if (sec_q == 6'd59) begin
                sec_d = '0;
                if (min_q == 6'd59) begin
                    min_d  = '0;
                    hour_d = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end

`ifdef CLOCK_CORE_ALARM_EN
        amin_d   = amin_q;
        ahour_d  = ahour_q;
        armed_d  = armed_q;
`endif

        if (wr) begin
            case (set.set_sel)
                3'd0:    sec_d   = set.set_value[5:0];
                3'd1:    min_d   = set.set_value[5:0];
                3'd2:    hour_d  = set.set_value[4:0];
`ifdef CLOCK_CORE_ALARM_EN
                3'd3:    amin_d  = set.set_value[5:0];
                3'd4:    ahour_d = set.set_value[4:0];
                3'd5:    armed_d = set.set_value[0];
`endif
                default: ;
            endcase
        end

        ready_d  = ~accept;
        err_d    = accept & ~legal;
        tick_d   = tick;

`ifdef CLOCK_CORE_ALARM_EN
        state_d  = state_q;
        ring_d   = ring_q;
        case (state_q)
            IDLE: begin
                // Only a tick can trigger; writing the alarm time directly does not.
                if (tick && armed_d && sec_d == 6'd0 && min_d == amin_d &&
                    hour_d == ahour_d) begin
                    state_d = RING;
                    ring_d  = RING_LOAD;
                end
            end
            RING: begin
                if (wr && set.set_sel == 3'd5 && !set.set_value[0]) begin
                    state_d = IDLE;
                    ring_d  = '0;
                end else if (tick) begin
                    ring_d = ring_q - 6'd1;
                    if (ring_q == 6'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        alarm_d  = (state_d == RING);
        sec_o_d  = (state_d == RING && ring_d[0]) ? 7'd60 : {1'b0, sec_d};
`else
        sec_o_d  = {1'b0, sec_d};
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
            sec_o_q <= '0;
            tick_q  <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            sec_o_q <= sec_o_d;
            tick_q  <= tick_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

`ifdef CLOCK_CORE_ALARM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ring_q  <= '0;
            amin_q  <= '0;
            ahour_q <= '0;
            armed_q <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ring_q  <= ring_d;
            amin_q  <= amin_d;
            ahour_q <= ahour_d;
            armed_q <= armed_d;
            alarm_q <= alarm_d;
        end
    end

    assign alarm_o = alarm_q;
`else
    assign alarm_o = 1'b0;
`endif

    assign sec_o         = sec_o_q;
    assign min_o         = {1'b0, min_q};
    assign hour_o        = {2'b00, hour_q};
    assign tick_o        = tick_q;
    assign set.set_ready = ready_q;
    assign set.set_err   = err_q;

endmodule

// File: tb/tb_clock_core.sv
// tb_clock_core -- directed bench for clock_core with TICK_DIV=4, ALARM_SECS=4.
// Alarm scenarios are compiled when CLOCK_CORE_ALARM_EN is defined; otherwise
// the bench checks that alarm-field writes are rejected.
module tb_clock_core;

    logic       clk;
    logic       rst_n;
    logic [6:0] sec_o;
    logic [6:0] min_o;
    logic [6:0] hour_o;
    logic       tick_o;
    logic       alarm_o;

    int total;
    int bad;

    clock_core_if bus ();

    clock_core #(
        .TICK_DIV   (4),
        .ALARM_SECS (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .set     (bus),
        .sec_o   (sec_o),
        .min_o   (min_o),
        .hour_o  (hour_o),
        .tick_o  (tick_o),
        .alarm_o (alarm_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one write and advances through its acceptance edge.
    task automatic wr(input logic [2:0] sel, input logic [6:0] val);
        bus.set_sel   = sel;
        bus.set_value = val;
        bus.set_valid = 1'b1;
        step();
        bus.set_valid = 1'b0;
    endtask

    // Write plus the idle cycle while set_ready recovers.
    task automatic wr2(input logic [2:0] sel, input logic [6:0] val);
        wr(sel, val);
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.set_valid = 1'b0;
        bus.set_sel = '0;
        bus.set_value = '0;
        step();
        step();
        total++; if (sec_o !== 7'd0) begin bad++; $display("FAIL rst_sec got=%0d exp=0", sec_o); end
        total++; if (min_o !== 7'd0) begin bad++; $display("FAIL rst_min got=%0d exp=0", min_o); end
        total++; if (hour_o !== 7'd0) begin bad++; $display("FAIL rst_hour got=%0d exp=0", hour_o); end
        total++; if (tick_o !== 1'b0) begin bad++; $display("FAIL rst_tick got=%0b exp=0", tick_o); end
        total++; if (alarm_o !== 1'b0) begin bad++; $display("FAIL rst_alarm got=%0b exp=0", alarm_o); end
        total++; if (bus.set_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b exp=0", bus.set_ready); end
        total++; if (bus.set_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b exp=0", bus.set_err); end
        rst_n = 1'b1;
        step();
        total++; if (bus.set_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_rise got=%0b exp=1", bus.set_ready); end
    endtask

    task automatic test_rollover();
        wr2(3'd2, 7'd23);
        wr2(3'd1, 7'd59);
        wr(3'd0, 7'd58);
        total++; if (sec_o !== 7'd58) begin bad++; $display("FAIL roll_sec_write got=%0d exp=58", sec_o); end
        step();
        // sec write cleared the prescaler: tick lands on the 4th edge after acceptance
        step();
        total++; if (tick_o !== 1'b0) begin bad++; $display("FAIL roll_early_tick got=%0b exp=0", tick_o); end
        step();
        total++; if (tick_o !== 1'b0) begin bad++; $display("FAIL roll_early_tick2 got=%0b exp=0", tick_o); end
        step();
        total++; if (tick_o !== 1'b1) begin bad++; $display("FAIL roll_tick1 got=%0b exp=1", tick_o); end
        total++; if ({hour_o, min_o, sec_o} !== {7'd23, 7'd59, 7'd59})
            begin bad++; $display("FAIL roll_t1 got=%0d:%0d:%0d exp=23:59:59", hour_o, min_o, sec_o); end
        step();
        total++; if (tick_o !== 1'b0) begin bad++; $display("FAIL roll_tick_pulse got=%0b exp=0", tick_o); end
        step();
        step();
        step();
        total++; if (tick_o !== 1'b1) begin bad++; $display("FAIL roll_tick2 got=%0b exp=1", tick_o); end
        total++; if ({hour_o, min_o, sec_o} !== {7'd0, 7'd0, 7'd0})
            begin bad++; $display("FAIL roll_t2 got=%0d:%0d:%0d exp=0:0:0", hour_o, min_o, sec_o); end
    endtask

    task automatic test_range();
        wr(3'd0, 7'd60);
        total++; if (bus.set_err !== 1'b1) begin bad++; $display("FAIL rng_err_sec got=%0b exp=1", bus.set_err); end
        total++; if (bus.set_ready !== 1'b0) begin bad++; $display("FAIL rng_ready_low got=%0b exp=0", bus.set_ready); end
        total++; if (sec_o !== 7'd0) begin bad++; $display("FAIL rng_sec_keep got=%0d exp=0", sec_o); end
        step();
        total++; if (bus.set_err !== 1'b0) begin bad++; $display("FAIL rng_err_pulse got=%0b exp=0", bus.set_err); end
        total++; if (bus.set_ready !== 1'b1) begin bad++; $display("FAIL rng_ready_back got=%0b exp=1", bus.set_ready); end
        wr(3'd7, 7'd0);
        total++; if (bus.set_err !== 1'b1) begin bad++; $display("FAIL rng_err_sel7 got=%0b exp=1", bus.set_err); end
        total++; if (bus.set_ready !== 1'b0) begin bad++; $display("FAIL rng_ready_sel7 got=%0b exp=0", bus.set_ready); end
        step();
        // illegal writes leave the prescaler alone, so this edge is a tick
        total++; if (bus.set_err !== 1'b0) begin bad++; $display("FAIL rng_err_sel7_pulse got=%0b exp=0", bus.set_err); end
        total++; if (tick_o !== 1'b1) begin bad++; $display("FAIL rng_tick got=%0b exp=1", tick_o); end
        total++; if (sec_o !== 7'd1) begin bad++; $display("FAIL rng_sec_adv got=%0d exp=1", sec_o); end
    endtask

    task automatic test_collision();
        step();
        step();
        step();
        wr(3'd1, 7'd30);
        total++; if (min_o !== 7'd30) begin bad++; $display("FAIL col_min got=%0d exp=30", min_o); end
        total++; if (sec_o !== 7'd1) begin bad++; $display("FAIL col_sec got=%0d exp=1", sec_o); end
        total++; if (tick_o !== 1'b0) begin bad++; $display("FAIL col_tick got=%0b exp=0", tick_o); end
        step();
        step();
        step();
        step();
        total++; if (tick_o !== 1'b1) begin bad++; $display("FAIL col_next_tick got=%0b exp=1", tick_o); end
        total++; if ({min_o, sec_o} !== {7'd30, 7'd2})
            begin bad++; $display("FAIL col_next_time got=%0d:%0d exp=30:2", min_o, sec_o); end
    endtask

`ifdef CLOCK_CORE_ALARM_EN
    task automatic test_ring();
        logic [6:0] exp_sec [4];
        exp_sec[0] = 7'd60;
        exp_sec[1] = 7'd2;
        exp_sec[2] = 7'd60;
        exp_sec[3] = 7'd4;
        wr(3'd4, 7'd7);
        total++; if (bus.set_err !== 1'b0) begin bad++; $display("FAIL ring_ahour_err got=%0b exp=0", bus.set_err); end
        step();
        wr2(3'd3, 7'd0);
        wr2(3'd5, 7'd1);
        wr2(3'd2, 7'd6);
        wr2(3'd1, 7'd59);
        wr2(3'd0, 7'd59);
        step();
        step();
        step();
        total++; if (alarm_o !== 1'b1) begin bad++; $display("FAIL ring_start got=%0b exp=1", alarm_o); end
        total++; if ({hour_o, min_o, sec_o} !== {7'd7, 7'd0, 7'd0})
            begin bad++; $display("FAIL ring_t0 got=%0d:%0d:%0d exp=7:0:0", hour_o, min_o, sec_o); end
        for (int i = 0; i < 4; i++) begin
            step();
            step();
            step();
            step();
            total++; if (sec_o !== exp_sec[i]) begin bad++; $display("FAIL ring_sec_%0d got=%0d exp=%0d", i, sec_o, exp_sec[i]); end
            total++; if (alarm_o !== (i < 3)) begin bad++; $display("FAIL ring_alarm_%0d got=%0b exp=%0b", i, alarm_o, (i < 3)); end
        end
    endtask

    task automatic test_stop();
        wr2(3'd2, 7'd6);
        wr2(3'd1, 7'd59);
        wr2(3'd0, 7'd59);
        step();
        step();
        step();
        total++; if (alarm_o !== 1'b1) begin bad++; $display("FAIL stop_retrigger got=%0b exp=1", alarm_o); end
        wr(3'd5, 7'd1);
        total++; if (alarm_o !== 1'b1) begin bad++; $display("FAIL stop_arm_keeps got=%0b exp=1", alarm_o); end
        step();
        step();
        step();
        total++; if (sec_o !== 7'd60) begin bad++; $display("FAIL stop_blank got=%0d exp=60", sec_o); end
        wr(3'd5, 7'd0);
        total++; if (alarm_o !== 1'b0) begin bad++; $display("FAIL stop_alarm got=%0b exp=0", alarm_o); end
        total++; if (sec_o !== 7'd1) begin bad++; $display("FAIL stop_sec_true got=%0d exp=1", sec_o); end
        step();
    endtask

    task automatic test_reset_mid_ring();
        wr2(3'd5, 7'd1);
        wr2(3'd2, 7'd6);
        wr2(3'd1, 7'd59);
        wr2(3'd0, 7'd59);
        step();
        step();
        step();
        total++; if (alarm_o !== 1'b1) begin bad++; $display("FAIL rmr_ringing got=%0b exp=1", alarm_o); end
        rst_n = 1'b0;
        step();
        total++; if ({alarm_o, tick_o, bus.set_ready, bus.set_err} !== 4'b0000)
            begin bad++; $display("FAIL rmr_flags got=%b exp=0000", {alarm_o, tick_o, bus.set_ready, bus.set_err}); end
        total++; if ({hour_o, min_o, sec_o} !== 21'd0)
            begin bad++; $display("FAIL rmr_time got=%0d:%0d:%0d exp=0:0:0", hour_o, min_o, sec_o); end
        rst_n = 1'b1;
        step();
        total++; if (bus.set_ready !== 1'b1) begin bad++; $display("FAIL rmr_ready got=%0b exp=1", bus.set_ready); end
        // alarm regs are 00:00 after reset; a disarmed core must not ring at midnight
        wr2(3'd2, 7'd23);
        wr2(3'd1, 7'd59);
        wr2(3'd0, 7'd59);
        step();
        step();
        step();
        total++; if (tick_o !== 1'b1) begin bad++; $display("FAIL rmr_midnight_tick got=%0b exp=1", tick_o); end
        total++; if (alarm_o !== 1'b0) begin bad++; $display("FAIL rmr_disarmed got=%0b exp=0", alarm_o); end
    endtask
`else
    task automatic test_alarm_disabled();
        wr(3'd3, 7'd5);
        total++; if (bus.set_err !== 1'b1) begin bad++; $display("FAIL noal_sel3_err got=%0b exp=1", bus.set_err); end
        step();
        wr(3'd5, 7'd1);
        total++; if (bus.set_err !== 1'b1) begin bad++; $display("FAIL noal_sel5_err got=%0b exp=1", bus.set_err); end
        total++; if (alarm_o !== 1'b0) begin bad++; $display("FAIL noal_alarm got=%0b exp=0", alarm_o); end
        step();
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_rollover();
        test_range();
        test_collision();
`ifdef CLOCK_CORE_ALARM_EN
        test_ring();
        test_stop();
        test_reset_mid_ring();
`else
        test_alarm_disabled();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_core.md
# clock_core

Timekeeping stage of the digital clock, directly upstream of the six-digit display driver. Divides the board clock into a one-second tick and maintains hours/minutes/seconds in binary. Accepts field writes from the serial command decoder over a valid/ready handshake and runs a programmable alarm. Its `sec_o`/`min_o`/`hour_o` outputs drive the display's seconds, minutes and hours inputs; during ringing it forces the seconds bus to the value 60, which the display renders as the blanking pattern.

## Interface
- `TICK_DIV`, 50_000_000: clk cycles per second; must be ≥ 2.
- `ALARM_SECS`, 10: ring duration in seconds, 1..63.

- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `set_valid` in 1: write request from the command decoder.
- `set_ready` out 1: block can accept a write.
- `set_sel` in 3: field select. 0 = sec, 1 = min, 2 = hour, 3 = alarm min, 4 = alarm hour, 5 = alarm control (`set_value[0]` is the armed flag).
- `set_value` in 7: binary field value.
- `set_err` out 1: one-cycle pulse when an accepted write is out of range.
- `sec_o` out 7: seconds 0..59, or 60 for the blank phase.
- `min_o` out 7: minutes 0..59.
- `hour_o` out 7: hours 0..23.
- `tick_o` out 1: one-cycle pulse aligned with each one-second update.
- `alarm_o` out 1: high while ringing.

## Operation
- **Reset.** While `rst_n` = 0 at an edge:
  - prescaler, sec, min, hour, alarm min, alarm hour = 0;
  - armed = 0, ringing = 0, ring counter = 0;
  - outputs: `sec_o`/`min_o`/`hour_o` = 0, `tick_o` = 0, `alarm_o` = 0, `set_err` = 0, `set_ready` = 0.
  - `set_ready` goes to 1 on the first edge with `rst_n` = 1.
  - Reset mid-ring or mid-handshake aborts immediately; no pending write survives.
- **Prescaler.** Counts 0..TICK_DIV-1. The edge at which it equals TICK_DIV-1 is a tick edge: prescaler → 0 and time advances.
- **Advance.**
  - sec+1; sec 59 → 0 and carries to min.
  - min 59 → 0 and carries to hour.
  - hour 23 → 0.
  - Therefore 23:59:59 → 00:00:00 in one tick.
- **Write handshake.**
  - A write is accepted when `set_valid & set_ready` at an edge.
  - `set_ready` drops to 0 for exactly the next cycle, then returns to 1.
  - The new field value is visible the cycle after acceptance.
- **Range check.** Legal ranges: sec and min 0..59, hour 0..23, alarm min 0..59, alarm hour 0..23, sel 5 any value. `set_sel` 6 or 7 is also illegal.
  - An illegal write is still accepted (handshake completes) but changes nothing.
  - `set_err` = 1 for the cycle after acceptance.
- **Sec write.** Also clears the prescaler, so the next tick comes a full TICK_DIV cycles later.
- **Write vs tick in the same edge.**
  - Legal time-field write (sel 0..2): the write wins; the tick is discarded, with no increment or carry in any field; `tick_o` stays 0.
  - Alarm-field write (sel 3..5): the tick is applied normally.
- **Alarm FSM.** States: IDLE, RING.
  - IDLE → RING on a tick edge whose resulting time equals alarm hour : alarm min : 00 while armed = 1. Ring counter loads ALARM_SECS.
  - In RING, each tick decrements the ring counter. RING → IDLE when the counter reaches 0.
  - RING → IDLE immediately on a sel 5 write with value bit0 = 0; this also disarms.
  - A sel 5 write with bit0 = 1 during RING does not stop ringing.
  - Writing time fields during RING does not stop ringing.
  - Writing time to exactly the alarm time does not trigger; only a tick transition triggers.
- **Outputs during RING.**
  - `alarm_o` = 1.
  - `sec_o` = 60 when the ring counter is odd, true seconds when it is even.
  - `min_o`/`hour_o` always show true time.

## Timing
- All outputs are registered.
- Tick edge: new time and `tick_o` = 1 appear together in the following cycle.
- Time between ticks is TICK_DIV cycles, except that a sec write restarts the count.
- Write latency: one cycle from acceptance to output.
- Maximum write throughput: one write per two cycles.
- RING lasts exactly ALARM_SECS ticks; `alarm_o` falls in the same cycle the final decrement becomes visible.

## Configuration
- `CLOCK_CORE_ALARM_EN` defined: alarm registers, FSM and sec-60 blanking are compiled in, as described above.
- `CLOCK_CORE_ALARM_EN` undefined:
  - no alarm logic; `alarm_o` tied to 0;
  - `sec_o` never shows 60;
  - sel 3..5 writes are treated as illegal: accepted, `set_err` pulses, no state change.

## Test plan
- **Rollover.** TICK_DIV=4. Write hour 23, min 59, sec 58, then run 2 ticks → 23:59:59, then 00:00:00; `tick_o` pulses once per 4 cycles.
- **Handshake and range check.** Write sec 60 → `set_err` pulses one cycle, sec unchanged, `set_ready` low for one cycle. Write sel 7 → same response.
- **Collision.** Write min 30 on the exact tick edge → min = 30, sec unchanged, no `tick_o` that cycle.
- **Ringing.** Alarm 07:00, armed, time 06:59:59, ALARM_SECS=4, then one tick → `alarm_o` = 1. `sec_o` sequence over the ring: 0, 60, 2, 60. `alarm_o` drops after 4 ticks.
- **Stop.** During RING, write sel 5 value 0 → `alarm_o` = 0 the next cycle and `sec_o` shows true seconds. Repeat with sel 5 value 1 → ringing continues.
- **Reset mid-ring.** Pull `rst_n` low for 1 cycle during RING → all outputs 0 and armed = 0; `set_ready` = 1 on the following cycle.
